// File: rtl/wb_pkg.sv
// Shared definitions for the writeback/scoreboard stage.
// WB_N / WB_R / WB_D are the default data width, register index width and
// memory-result FIFO depth. wb_entry_t is one buffered memory result. Its
// field widths follow WB_N / WB_R.
package wb_pkg;

    localparam int WB_N = 32;
    localparam int WB_R = 7;
    localparam int WB_D = 4;

    typedef struct packed {
        logic [WB_R-1:0] rd;
        logic [WB_N-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO that holds memory results waiting for the write port.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata     write one entry (the caller never pushes when full)
//   pop,  rdata     rdata is the current head; pop advances past it
//   full, empty     derived from the registered occupancy
//   count           occupancy, 0..D
// The pointers are one bit wider than the index. Equal pointers mean empty.
// Indices that are equal but differ in the MSB mean full.
module wb_fifo #(
    parameter int W = 39,
    parameter int D = 4,
    localparam int AW = $clog2(D)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    logic [W-1:0] mem [D];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset: after reset the pointers make every slot invalid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign count = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (count == (AW+1)'(D));

endmodule

// File: rtl/wb_scoreboard.sv
// Writeback / scoreboard stage in front of the register file write port.
// Keeps one busy bit per register. It stalls issue on RAW and WAW hazards.
// It merges ALU results and memory results onto one registered write port.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   issueValid/Rs1/Rs2/Rd/Wr     decode request
//   issueStall                   decode must hold the instruction (combinational)
//   aluValid/aluReg/aluData      ALU result; always accepted, has priority
//   memValid/memReg/memData      memory result
//   memReady                     handshake back to the memory unit
//   regWrite/writeReg/writeData  registered register file write port
//   busyVec                      busy bits, for debug
// Optional: define WB_SCOREBOARD_PERF_EN to add the stallCycles and
// fifoHighWater counters.
// The FIFO entry type comes from wb_pkg. Overriding n or r therefore also
// needs matching package defaults.
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int n = WB_N,
    parameter int r = WB_R,
    parameter int D = WB_D
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issueValid,
    input  logic [r-1:0]      issueRs1,
    input  logic [r-1:0]      issueRs2,
    input  logic [r-1:0]      issueRd,
    input  logic              issueWr,
    output logic              issueStall,
    input  logic              aluValid,
    input  logic [r-1:0]      aluReg,
    input  logic [n-1:0]      aluData,
    input  logic              memValid,
    output logic              memReady,
    input  logic [r-1:0]      memReg,
    input  logic [n-1:0]      memData,
    output logic              regWrite,
    output logic [r-1:0]      writeReg,
    output logic [n-1:0]      writeData,
    output logic [2**r-1:0]   busyVec
`ifdef WB_SCOREBOARD_PERF_EN
    ,
    output logic [31:0]       stallCycles,
    output logic [$clog2(D):0] fifoHighWater
`endif
);

    localparam int CW = $clog2(D) + 1;

    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          fifo_push;
    logic          fifo_pop;
    wb_entry_t     push_entry;
    wb_entry_t     head;
    logic [$bits(wb_entry_t)-1:0] head_raw;

    logic          mem_xfer;
    logic          issue_set;
    logic          sel_valid;
    logic [r-1:0]  sel_reg;
    logic [n-1:0]  sel_data;
    logic [2**r-1:0] busy_next;

    assign issueStall = issueValid &&
                        ((busyVec[issueRs1] && issueRs1 != '0) ||
                         (busyVec[issueRs2] && issueRs2 != '0) ||
                         (issueWr && busyVec[issueRd]));
    assign issue_set  = issueValid && !issueStall && issueWr && issueRd != '0;

    // memReady uses the registered count. A full FIFO still refuses a new
    // result in a cycle that also pops.
    assign memReady   = !fifo_full;
    assign mem_xfer   = memValid && memReady;
    assign fifo_pop   = !aluValid && !fifo_empty;
    // A memory result skips the FIFO only if nothing is queued ahead of it
    // and the ALU is not using the port this cycle.
    assign fifo_push  = mem_xfer && (aluValid || !fifo_empty);

    assign push_entry.rd   = memReg;
    assign push_entry.data = memData;
    assign head            = wb_entry_t'(head_raw);

    wb_fifo #(.W($bits(wb_entry_t)), .D(D)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (push_entry),
        .rdata (head_raw),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_reg   = '0;
        sel_data  = '0;
        if (aluValid) begin
            sel_valid = 1'b1;
            sel_reg   = aluReg;
            sel_data  = aluData;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_reg   = head.rd;
            sel_data  = head.data;
        end else if (mem_xfer) begin
            sel_valid = 1'b1;
            sel_reg   = memReg;
            sel_data  = memData;
        end
    end

    // The clear comes first so that a set on the same edge wins. Register 0
    // is forced idle.
    always_comb begin
        busy_next = busyVec;
        if (regWrite)  busy_next[writeReg] = 1'b0;
        if (issue_set) busy_next[issueRd]  = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
            busyVec   <= '0;
        end else begin
            busyVec  <= busy_next;
            regWrite <= sel_valid && (sel_reg != '0);
            if (sel_valid && sel_reg != '0) begin
                writeReg  <= sel_reg;
                writeData <= sel_data;
            end
        end
    end

`ifdef WB_SCOREBOARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCycles   <= '0;
            fifoHighWater <= '0;
        end else begin
            if (issueStall && stallCycles != '1) stallCycles <= stallCycles + 1'b1;
            if (fifo_count > fifoHighWater)      fifoHighWater <= fifo_count;
        end
    end
`endif

endmodule

// File: tb/tb_wb_scoreboard.sv
module tb_wb_scoreboard;

    localparam int N = 32;
    localparam int R = 7;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issueValid;
    logic [R-1:0]  issueRs1, issueRs2, issueRd;
    logic          issueWr;
    logic          issueStall;
    logic          aluValid;
    logic [R-1:0]  aluReg;
    logic [N-1:0]  aluData;
    logic          memValid;
    logic          memReady;
    logic [R-1:0]  memReg;
    logic [N-1:0]  memData;
    logic          regWrite;
    logic [R-1:0]  writeReg;
    logic [N-1:0]  writeData;
    logic [2**R-1:0] busyVec;
`ifdef WB_SCOREBOARD_PERF_EN
    logic [31:0]   stallCycles;
    logic [$clog2(D):0] fifoHighWater;
`endif

    logic [N-1:0]  rf [2**R];
    int total  = 0;
    int passed = 0;
    int k;
    logic acc;

    always #5 clk = ~clk;

    always @(posedge clk) if (regWrite) rf[writeReg] <= writeData;

    wb_scoreboard #(.n(N), .r(R), .D(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .issueValid(issueValid), .issueRs1(issueRs1), .issueRs2(issueRs2),
        .issueRd(issueRd), .issueWr(issueWr), .issueStall(issueStall),
        .aluValid(aluValid), .aluReg(aluReg), .aluData(aluData),
        .memValid(memValid), .memReady(memReady), .memReg(memReg), .memData(memData),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .busyVec(busyVec)
`ifdef WB_SCOREBOARD_PERF_EN
        , .stallCycles(stallCycles), .fifoHighWater(fifoHighWater)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        issueValid = 0; issueRs1 = 0; issueRs2 = 0; issueRd = 0; issueWr = 0;
        aluValid = 0; aluReg = 0; aluData = 0;
        memValid = 0; memReg = 0; memData = 0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        aluValid = 1; aluReg = 7'd1; aluData = 32'hAB;
        repeat (3) @(negedge clk);
        chk("rst_regwrite", regWrite, 0);
        chk("rst_busy", busyVec, 0);
        chk("rst_memready", memReady, 1);
        chk("rst_writereg", writeReg, 0);
        chk("rst_writedata", writeData, 0);
        rst_n = 1;
        #1 chk("rel_regwrite", regWrite, 0);
        @(negedge clk);
        chk("rel_alu_we", regWrite, 1);
        chk("rel_alu_reg", writeReg, 1);
        chk("rel_alu_data", writeData, 32'hAB);
        aluValid = 0;
        @(negedge clk);
        chk("rel_idle_we", regWrite, 0);

        // RAW stall on r5
        issueValid = 1; issueWr = 1; issueRd = 7'd5;
        #1 chk("raw_first_stall", issueStall, 0);
        @(negedge clk);
        chk("raw_busy5", busyVec[5], 1);
        issueWr = 0; issueRd = 0; issueRs1 = 7'd5;
        aluValid = 1; aluReg = 7'd5; aluData = 32'hDEAD;
        #1 chk("raw_stall", issueStall, 1);
        @(negedge clk);
        aluValid = 0;
        chk("raw_we", regWrite, 1);
        chk("raw_reg", writeReg, 5);
        chk("raw_data", writeData, 32'hDEAD);
        chk("raw_stall_hold", issueStall, 1);
        @(negedge clk);
        chk("raw_stall_drop", issueStall, 0);
        chk("raw_busy_clr", busyVec, 0);
        chk("raw_rf5", rf[5], 32'hDEAD);
`ifdef WB_SCOREBOARD_PERF_EN
        chk("perf_stall", stallCycles, 2);
`endif
        idle_inputs();

        // mem bypass with empty FIFO
        memValid = 1; memReg = 7'd6; memData = 32'h66;
        @(negedge clk);
        memValid = 0;
        chk("byp_we", regWrite, 1);
        chk("byp_reg", writeReg, 6);
        chk("byp_data", writeData, 32'h66);
        chk("byp_cnt", dut.u_fifo.count, 0);

        // collision
        aluValid = 1; aluReg = 7'd3; aluData = 32'h11;
        memValid = 1; memReg = 7'd4; memData = 32'h22;
        #1 chk("col_ready", memReady, 1);
        @(negedge clk);
        idle_inputs();
        chk("col_reg1", writeReg, 3);
        chk("col_data1", writeData, 32'h11);
        chk("col_cnt", dut.u_fifo.count, 1);
        @(negedge clk);
        chk("col_we2", regWrite, 1);
        chk("col_reg2", writeReg, 4);
        chk("col_data2", writeData, 32'h22);
        chk("col_cnt2", dut.u_fifo.count, 0);
        @(negedge clk);
        chk("col_idle", regWrite, 0);

        // FIFO full: ALU busy every cycle, producer holds an item until it is accepted
        k = 0;
        for (int c = 0; c < 6; c++) begin
            aluValid = 1; aluReg = 7'(20 + c); aluData = 32'(c);
            memValid = 1; memReg = 7'(10 + k); memData = 32'h100 + 32'(k);
            #1 chk("full_ready", memReady, (c < 4) ? 1 : 0);
            acc = memReady;
            @(negedge clk);
            if (acc) k++;
            chk("full_alu_reg", writeReg, 20 + c);
        end
        chk("full_cnt", dut.u_fifo.count, 4);
        aluValid = 0;
        for (int j = 0; j < 6; j++) begin
            if (k < 6) begin
                memValid = 1; memReg = 7'(10 + k); memData = 32'h100 + 32'(k);
            end else begin
                memValid = 0;
            end
            #1 chk("drain_ready", memReady, (j != 0) ? 1 : 0);
            acc = memValid && memReady;
            @(negedge clk);
            if (acc) k++;
            chk("drain_we", regWrite, 1);
            chk("drain_reg", writeReg, 10 + j);
            chk("drain_data", writeData, 32'h100 + j);
        end
        idle_inputs();
        @(negedge clk);
        chk("drain_idle", regWrite, 0);
        chk("drain_cnt", dut.u_fifo.count, 0);
`ifdef WB_SCOREBOARD_PERF_EN
        chk("perf_hw", fifoHighWater, 4);
`endif

        // register 0
        issueValid = 1; issueWr = 1; issueRd = 0;
        #1 chk("r0_stall_wr", issueStall, 0);
        @(negedge clk);
        chk("r0_busy", busyVec[0], 0);
        issueWr = 0; issueRs1 = 0;
        aluValid = 1; aluReg = 0; aluData = 32'hFF;
        #1 chk("r0_stall_rs", issueStall, 0);
        @(negedge clk);
        chk("r0_no_we", regWrite, 0);
        chk("r0_busy2", busyVec, 0);
        idle_inputs();

        // reset mid-drain
        issueValid = 1; issueWr = 1; issueRd = 7'd7;
        @(negedge clk);
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            aluValid = 1; aluReg = 7'(1 + c); aluData = 32'(c);
            memValid = 1; memReg = 7'(8 + c); memData = 32'(c);
            @(negedge clk);
        end
        idle_inputs();
        chk("mid_cnt", dut.u_fifo.count, 3);
        chk("mid_busy7", busyVec[7], 1);
        chk("mid_we", regWrite, 1);
        #2 rst_n = 0;
        #1 chk("mid_rst_we", regWrite, 0);
        chk("mid_rst_busy", busyVec, 0);
        chk("mid_rst_cnt", dut.u_fifo.count, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("post_we", regWrite, 0);
        chk("post_cnt", dut.u_fifo.count, 0);
        chk("post_ready", memReady, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
